// File: rtl/flex_rollover_counter.sv
// Up-counter with a programmable terminal value and a synchronous clear.
// The count runs 1..rollover_val and wraps to 1; the registered flag marks the terminal count.
module flex_rollover_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  localparam logic [NUM_CNT_BITS-1:0] ONE = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] next_count;
  logic                    next_flag;
  logic                    at_rollover;

  assign at_rollover = (count_out == rollover_val);

  always_comb begin
    next_count = count_out;
    next_flag  = 1'b0;
    if (clear) begin
      next_count = '0;
      next_flag  = 1'b0;
    end else if (count_enable) begin
      next_count = at_rollover ? ONE : count_out + ONE;
      next_flag  = (next_count == rollover_val);
    end else begin
      // An idle counter never raises the flag (reset/clear is not a rollover),
      // but drops it as soon as rollover_val moves away from the held count.
      next_flag = rollover_flag && at_rollover;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_out     <= '0;
      rollover_flag <= 1'b0;
    end else begin
      count_out     <= next_count;
      rollover_flag <= next_flag;
    end
  end

endmodule

// File: tb/tb_flex_rollover_counter.sv
// Directed scoreboard bench for flex_rollover_counter: a behavioural model pushes
// the expected count/flag per driven edge, and each result is popped after the edge.
module tb_flex_rollover_counter;

  localparam int N   = 4;
  localparam int MOD = 1 << N;

  logic         tb_clk = 1'b0;
  logic         rst;
  logic         clear;
  logic         count_enable;
  logic [N-1:0] rollover_val;
  logic [N-1:0] count_out;
  logic         rollover_flag;

  typedef struct {
    logic [N-1:0] cnt;
    logic         flg;
    string        tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;
  bit   model_flg = 1'b0;

  flex_rollover_counter #(.NUM_CNT_BITS(N)) dut (
    .clk          (tb_clk),
    .rst          (rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );

  always #5 tb_clk = ~tb_clk;

  // Behavioural reference written from the counting rules, one call per rising edge.
  function automatic void model_step(input logic clr, input logic en, input logic [N-1:0] rv);
    int r;
    r = int'(rv);
    if (clr) begin
      model_cnt = 0;
      model_flg = 1'b0;
    end else if (en) begin
      if (model_cnt == r) model_cnt = 1;
      else model_cnt = (model_cnt + 1) % MOD;
      model_flg = (model_cnt == r);
    end else begin
      model_flg = model_flg && (model_cnt == r);
    end
  endfunction

  function automatic void push_expected(input string tag);
    exp_t e;
    e.cnt = model_cnt[N-1:0];
    e.flg = model_flg;
    e.tag = tag;
    sb.push_back(e);
  endfunction

  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty got %0d entries want >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (count_out === e.cnt) else begin
        errors++;
        $error("[TB] FAIL %s count got %0d want %0d", e.tag, count_out, e.cnt);
      end
      checks++;
      assert (rollover_flag === e.flg) else begin
        errors++;
        $error("[TB] FAIL %s flag got %0b want %0b", e.tag, rollover_flag, e.flg);
      end
    end
  endtask

  task automatic expect_now(input string tag);
    push_expected(tag);
    checkOutput();
  endtask

  // Drive one edge's worth of inputs away from the edge, then check just after it.
  task automatic applyStimulus(input logic clr, input logic en, input logic [N-1:0] rv,
                               input string tag);
    @(negedge tb_clk);
    clear        = clr;
    count_enable = en;
    rollover_val = rv;
    model_step(clr, en, rv);
    push_expected(tag);
    @(posedge tb_clk);
    #1;
    checkOutput();
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any edge, released after an edge.
  task automatic pulse_reset(input string tag);
    @(negedge tb_clk);
    count_enable = 1'b0;
    clear        = 1'b0;
    rst          = 1'b1;
    model_cnt    = 0;
    model_flg    = 1'b0;
    #1;
    expect_now({tag, "_async"});
    @(posedge tb_clk);
    #1;
    expect_now({tag, "_hold"});
    rst = 1'b0;
    #1;
    expect_now({tag, "_release"});
  endtask

  initial begin
    rst          = 1'b1;
    clear        = 1'b0;
    count_enable = 1'b0;
    rollover_val = 4'd15;

    // Power-on reset
    #5;
    expect_now("por_half");
    @(posedge tb_clk);
    #1;
    expect_now("por_full");
    rst = 1'b0;
    #1;
    expect_now("por_release");
    applyStimulus(1'b0, 1'b0, 4'd15, "por_idle");

    // Non-power-of-two rollover, R=3: 1,2,3(flag),1
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 4'd3, "r3");

    // Continuous counting, R=15, 22 edges from reset
    pulse_reset("rst_cont");
    for (int i = 0; i < 22; i++) applyStimulus(1'b0, 1'b1, 4'd15, "cont15");

    // Discontinuous counting, R=7: enable drops just after the third edge
    pulse_reset("rst_disc");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 4'd7, "disc_run");
    count_enable = 1'b0;
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 4'd7, "disc_hold");

    // Clear has priority over enable, then counting restarts at 1
    applyStimulus(1'b1, 1'b1, 4'd7, "clear_prio");
    applyStimulus(1'b0, 1'b1, 4'd7, "clear_restart");

    // Lower R below the count: must wrap 15->0 before reaching 3
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 4'd7, "pre_lower");
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b1, 4'd3, "lowered");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'd3, "flag_hold");
    applyStimulus(1'b0, 1'b0, 4'd5, "flag_drop_rv");

    // R=0: first edge 0->1, flag only on the natural wrap to 0
    pulse_reset("rst_r0");
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 1'b1, 4'd0, "r0");

    // Reset mid-count aborts immediately, then resumes 0->1
    pulse_reset("rst_mid");
    applyStimulus(1'b0, 1'b1, 4'd9, "resume");
    applyStimulus(1'b0, 1'b1, 4'd9, "resume2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
